magia_fsync_node: RTL



---
 rtl/magia_fsync_pkg.sv | 15 +
 rtl/magia_fsync_slot.sv | 43 ++++
 rtl/magia_fsync_node.sv | 111 +++++++++++
 3 files changed

// File: rtl/magia_fsync_pkg.sv
// Shared types and constants for the MAGIA fractal-synchronisation tree nodes.
package magia_fsync_pkg;

  typedef enum logic {
    IDLE,
    WAIT_PAR
  } fsync_state_e;

  localparam int unsigned FSYNC_LVL_WIDTH = 3;
  typedef logic [FSYNC_LVL_WIDTH-1:0] fsync_lvl_t;

  // A request at this level completes at the current node; higher levels go up.
  localparam int unsigned FSYNC_LOCAL_LVL = 1;

endpackage

// File: rtl/magia_fsync_slot.sv
// Per-child barrier slot: holds one pending request and its level, and flags
// illegal (level 0) or duplicate requests with a one-cycle error pulse.
module magia_fsync_slot
  import magia_fsync_pkg::*;
#(
  parameter int unsigned LVL_WIDTH = FSYNC_LVL_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [LVL_WIDTH-1:0] lvl_i,
  input  logic                 clear_i,
  output logic                 pend_o,
  output logic [LVL_WIDTH-1:0] lvl_o,
  output logic                 err_o
);

  logic illegal;
  logic capture;

  assign illegal = (lvl_i == '0);
  // clear_i only fires while pend_o is set, so it never races a capture.
  assign capture = req_i && !illegal && !pend_o;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; lvl_o is reset too so no X can reach the parent level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_o <= 1'b0;
      lvl_o  <= '0;
      err_o  <= 1'b0;
    end else begin
      err_o <= req_i && (illegal || pend_o);
      if (clear_i) begin
        pend_o <= 1'b0;
      end else if (capture) begin
        pend_o <= 1'b1;
        lvl_o  <= lvl_i;
      end
    end
  end

endmodule

// File: rtl/magia_fsync_node.sv
// Two-child fractal-sync node: releases both children on a local match,
// forwards higher-level barriers to the parent, and flags level mismatches.
module magia_fsync_node
  import magia_fsync_pkg::*;
#(
  parameter int unsigned LVL_WIDTH = FSYNC_LVL_WIDTH,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0]                ch_req_i,
  input  logic [1:0][LVL_WIDTH-1:0] ch_lvl_i,
  output logic [1:0]                ch_wake_o,
  output logic [1:0]                ch_err_o,
  output logic                      par_req_o,
  output logic [LVL_WIDTH-1:0]      par_lvl_o,
  input  logic                      par_wake_i,
  output logic                      busy_o,
  output logic [CNT_WIDTH-1:0]      sync_cnt_o
);

  logic [1:0]                pend;
  logic [1:0][LVL_WIDTH-1:0] lvl_q;
  logic [1:0]                slot_err;
  logic                      clear;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    magia_fsync_slot #(
      .LVL_WIDTH(LVL_WIDTH)
    ) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (ch_req_i[i]),
      .lvl_i  (ch_lvl_i[i]),
      .clear_i(clear),
      .pend_o (pend[i]),
      .lvl_o  (lvl_q[i]),
      .err_o  (slot_err[i])
    );
  end

  fsync_state_e state_q, state_d;
  logic         both_pend, lvl_match, is_local;
  logic         wake_d, mism_d, par_req_d, cnt_inc;
  logic         mism_q;

  assign both_pend = &pend;
  assign lvl_match = (lvl_q[0] == lvl_q[1]);
  assign is_local  = (lvl_q[0] == LVL_WIDTH'(FSYNC_LOCAL_LVL));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    wake_d    = 1'b0;
    mism_d    = 1'b0;
    par_req_d = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // par_wake_i is deliberately ignored here.
        if (both_pend) begin
          if (!lvl_match) begin
            mism_d = 1'b1;
            clear  = 1'b1;
          end else if (is_local) begin
            wake_d  = 1'b1;
            clear   = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            par_req_d = 1'b1;
            state_d   = WAIT_PAR;
          end
        end
      end
      WAIT_PAR: begin
        if (par_wake_i) begin
          wake_d  = 1'b1;
          clear   = 1'b1;
          cnt_inc = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ch_wake_o  <= 2'b00;
      mism_q     <= 1'b0;
      par_req_o  <= 1'b0;
      par_lvl_o  <= '0;
      busy_o     <= 1'b0;
      sync_cnt_o <= '0;
    end else begin
      state_q   <= state_d;
      ch_wake_o <= {2{wake_d}};
      mism_q    <= mism_d;
      par_req_o <= par_req_d;
      busy_o    <= (state_d == WAIT_PAR);
      if (par_req_d) par_lvl_o <= lvl_q[0] - LVL_WIDTH'(1);
      if (cnt_inc)   sync_cnt_o <= sync_cnt_o + CNT_WIDTH'(1);
    end
  end

  // Capture errors and mismatch errors are both registered; only the merge is here.
  assign ch_err_o = slot_err | {2{mism_q}};

endmodule
